prf_wb_arbiter: RTL and testbench

//  Shares the physical register file's `ISSUE_WIDTH write ports among NUM_REQ completing functional units.

---
 rtl/prf_pkg.sv | 43 ++++
 rtl/prf_wb_arbiter_if.sv | 36 +++
 rtl/rr_multi_picker.sv | 55 +++++
 rtl/prf_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_prf_wb_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/prf_pkg.sv
// ---------------------------------------------------------------------------
// prf_pkg
// Shared physical-register-file types for the writeback path.
//
// Contents:
//   NUM_WB_REQ  default number of writeback requesters (functional units)
//   wb_req_t    one requester's {valid, addr, data}
//   wb_port_t   one PRF write port's {en, addr, data}
//
// The core-wide widths `ISSUE_WIDTH, `PRF_WIDTH, `XLEN and `ZERO_REG are
// normally supplied by the core configuration. This file gives them
// defaults, so it must be compiled before every file that uses them.
// ---------------------------------------------------------------------------
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 3
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 7
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

package prf_pkg;

  localparam int NUM_WB_REQ = 6;

  typedef struct packed {
    logic                  valid;
    logic [`PRF_WIDTH-1:0] addr;
    logic [`XLEN-1:0]      data;
  } wb_req_t;

  typedef struct packed {
    logic                  en;
    logic [`PRF_WIDTH-1:0] addr;
    logic [`XLEN-1:0]      data;
  } wb_port_t;

endpackage

// File: rtl/prf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// prf_wb_arbiter_if
// Bus between the completing functional units, the writeback arbiter and
// the PRF write ports.
//
//   req_valid/req_addr/req_data  FU -> arbiter: completed results
//   req_ready                    arbiter -> FU: grant (valid & ready = done)
//   wr_en/wr_addr/wr_data        arbiter -> PRF: registered write ports,
//                                also used as the wakeup/CDB broadcast
//
// Modports: master = requester/PRF side, slave = arbiter.
// ---------------------------------------------------------------------------
interface prf_wb_arbiter_if #(
  parameter int NUM_REQ = 6,
  parameter int NUM_WR  = `ISSUE_WIDTH
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][`PRF_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][`XLEN-1:0]      req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_WR-1:0]                  wr_en;
  logic [NUM_WR-1:0][`PRF_WIDTH-1:0]  wr_addr;
  logic [NUM_WR-1:0][`XLEN-1:0]       wr_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/rr_multi_picker.sv
// ---------------------------------------------------------------------------
// rr_multi_picker
// Combinational rotating-priority picker granting up to NUM_WR of NUM_REQ
// requests. Scan order is ptr, ptr+1, ... (mod NUM_REQ); the k-th request
// found is granted and steered to output slot k. Shared with issue-select.
//
// Ports:
//   req        in   NUM_REQ           request vector
//   ptr        in   PTR_W             highest-priority index
//   grant      out  NUM_REQ           granted requests
//   port_sel   out  NUM_WR x NUM_REQ  one-hot requester select per slot
//   port_used  out  NUM_WR            slot k received a grant
//   last_idx   out  PTR_W             index of the last grant in scan order
//   any_grant  out  1                 at least one grant this cycle
// ---------------------------------------------------------------------------
module rr_multi_picker #(
  parameter int NUM_REQ = 6,
  parameter int NUM_WR  = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [PTR_W-1:0]               ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_WR-1:0][NUM_REQ-1:0] port_sel,
  output logic [NUM_WR-1:0]              port_used,
  output logic [PTR_W-1:0]               last_idx,
  output logic                           any_grant
);

  always_comb begin
    int cnt;
    int idx;
    grant     = '0;
    port_sel  = '0;
    port_used = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    cnt       = 0;
    idx       = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      // ptr is always < NUM_REQ, so a single subtraction wraps correctly
      idx = int'(ptr) + o;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx] && (cnt < NUM_WR)) begin
        grant[idx]         = 1'b1;
        port_sel[cnt][idx] = 1'b1;
        port_used[cnt]     = 1'b1;
        last_idx           = PTR_W'(idx);
        any_grant          = 1'b1;
        cnt                = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// prf_wb_arbiter
// Shares the PRF write ports among NUM_REQ completing functional units.
// Up to NUM_WR valid requests are granted per cycle in rotating-priority
// order; granted writebacks are registered and drive the PRF write ports
// (and the wakeup broadcast) one cycle after the grant.
//
// Ports:
//   clk           in   1      clock, all state on posedge
//   rst_n         in   1      synchronous reset, active-low
//   bus           slave      requests in, req_ready / wr_* out
//   conflict_cnt  out  CNT_W  saturating count of cycles with more valid
//                             requests than write ports
//
// Optional feature, macro PRF_WB_ZERO_FILTER_EN:
//   defined   - requests to `ZERO_REG are acknowledged immediately without
//               using a write port, moving rr_ptr or counting as conflicts
//   undefined - `ZERO_REG requests arbitrate normally (PRF drops the write)
// ---------------------------------------------------------------------------
module prf_wb_arbiter
  import prf_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int NUM_WR  = `ISSUE_WIDTH,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  prf_wb_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  wb_req_t                    req_vec [NUM_REQ];
  logic [NUM_REQ-1:0]         arb_req;
  logic [NUM_REQ-1:0]         zero_hit;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_WR-1:0][NUM_REQ-1:0] port_sel;
  logic [NUM_WR-1:0]          port_used;
  logic [PTR_W-1:0]           last_idx;
  logic                       any_grant;
  logic                       over_sub;
  logic                       dup_addr;

  logic [PTR_W-1:0]           rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]           conflict_cnt_reg, conflict_cnt_next;
  wb_port_t                   wr_port_reg [NUM_WR];
  wb_port_t                   wr_port_next [NUM_WR];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_vec[gi] = '{valid: bus.req_valid[gi],
                             addr:  bus.req_addr[gi],
                             data:  bus.req_data[gi]};
`ifdef PRF_WB_ZERO_FILTER_EN
      // Zero-register writes are acknowledged and dropped right here
      assign zero_hit[gi] = req_vec[gi].valid &&
                            (req_vec[gi].addr == `PRF_WIDTH'(`ZERO_REG));
`else
      assign zero_hit[gi] = 1'b0;
`endif
      assign arb_req[gi] = req_vec[gi].valid & ~zero_hit[gi];
    end
  endgenerate

  rr_multi_picker #(
    .NUM_REQ (NUM_REQ),
    .NUM_WR  (NUM_WR),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (arb_req),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .port_sel  (port_sel),
    .port_used (port_used),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  // Handshake is suppressed during reset so nothing is consumed and lost
  assign bus.req_ready = rst_n ? (grant | zero_hit) : '0;

  // Write-port muxes: one-hot AND-OR select of the granted requester
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_port
      always_comb begin
        wr_port_next[gi] = wr_port_reg[gi];
        wr_port_next[gi].en = port_used[gi];
        if (port_used[gi]) begin
          wr_port_next[gi].addr = '0;
          wr_port_next[gi].data = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (port_sel[gi][i]) begin
              wr_port_next[gi].addr = wr_port_next[gi].addr | req_vec[i].addr;
              wr_port_next[gi].data = wr_port_next[gi].data | req_vec[i].data;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_port_reg[gi] <= '0;
        end else begin
          wr_port_reg[gi] <= wr_port_next[gi];
        end
      end

      assign bus.wr_en[gi]   = wr_port_reg[gi].en;
      assign bus.wr_addr[gi] = wr_port_reg[gi].addr;
      assign bus.wr_data[gi] = wr_port_reg[gi].data;
    end
  endgenerate

  // Oversubscription detect and duplicate-destination check
  always_comb begin
    int n;
    n        = 0;
    dup_addr = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_req[i]) n = n + 1;
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (req_vec[i].valid && req_vec[j].valid &&
            (req_vec[i].addr == req_vec[j].addr))
          dup_addr = 1'b1;
      end
    end
    over_sub = (n > NUM_WR);
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (any_grant) begin
      rr_ptr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
    conflict_cnt_next = conflict_cnt_reg;
    if (over_sub && (conflict_cnt_reg != '1)) begin
      conflict_cnt_next = conflict_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg       <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      rr_ptr_reg       <= rr_ptr_next;
      conflict_cnt_reg <= conflict_cnt_next;
      // Rename hands out unique destination tags; a clash is an upstream bug
      assert (!dup_addr);
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prf_wb_arbiter
// Directed bench for prf_wb_arbiter with NUM_REQ=6, NUM_WR=3.
// Adapts the zero-register scenario to PRF_WB_ZERO_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_prf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] conflict_cnt;
  int          pass_cnt;
  int          total_cnt;
  int          c0;

  prf_wb_arbiter_if #(.NUM_REQ(6), .NUM_WR(3)) bus ();

  prf_wb_arbiter #(.NUM_REQ(6), .NUM_WR(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [31:0] d);
    bus.req_addr[i] = a;
    bus.req_data[i] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 6'b111111;
    for (int i = 0; i < 6; i++) set_req(i, 7'(10 + i), 32'h100 + i);
    tick();
    $display("txn reset: wr_en=%b ready=%b cnt=%0d", bus.wr_en, bus.req_ready, conflict_cnt);
    total_cnt++; if (bus.wr_en !== 3'b000) $display("FAIL reset_wr_en: got %b want 000", bus.wr_en); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd0) $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr_reg); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 6'b000000) $display("FAIL reset_ready: got %b want 000000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.wr_addr[0] !== 7'd0) $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr[0]); else pass_cnt++;
    bus.req_valid = 6'b000000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rr_full();
    bus.req_valid = 6'b111111;
    #1;
    $display("txn rr_full c0: ready=%b", bus.req_ready);
    total_cnt++; if (bus.req_ready !== 6'b000111) $display("FAIL full_ready0: got %b want 000111", bus.req_ready); else pass_cnt++;
    tick();
    $display("txn rr_full c1: wr_en=%b a=%0d,%0d,%0d ready=%b", bus.wr_en, bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2], bus.req_ready);
    total_cnt++; if (bus.wr_en !== 3'b111) $display("FAIL full_wr_en0: got %b want 111", bus.wr_en); else pass_cnt++;
    total_cnt++; if (bus.wr_addr[0] !== 7'd10 || bus.wr_addr[1] !== 7'd11 || bus.wr_addr[2] !== 7'd12)
      $display("FAIL full_addr0: got %0d,%0d,%0d want 10,11,12", bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]); else pass_cnt++;
    total_cnt++; if (bus.wr_data[1] !== 32'h101) $display("FAIL full_data0: got %h want 00000101", bus.wr_data[1]); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd1) $display("FAIL full_cnt0: got %0d want 1", conflict_cnt); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd3) $display("FAIL full_ptr0: got %0d want 3", dut.rr_ptr_reg); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 6'b111000) $display("FAIL full_ready1: got %b want 111000", bus.req_ready); else pass_cnt++;
    tick();
    $display("txn rr_full c2: wr_en=%b a=%0d,%0d,%0d", bus.wr_en, bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]);
    total_cnt++; if (bus.wr_addr[0] !== 7'd13 || bus.wr_addr[1] !== 7'd14 || bus.wr_addr[2] !== 7'd15)
      $display("FAIL full_addr1: got %0d,%0d,%0d want 13,14,15", bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]); else pass_cnt++;
    total_cnt++; if (bus.wr_data[2] !== 32'h105) $display("FAIL full_data1: got %h want 00000105", bus.wr_data[2]); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd2) $display("FAIL full_cnt1: got %0d want 2", conflict_cnt); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd0) $display("FAIL full_ptr1: got %0d want 0", dut.rr_ptr_reg); else pass_cnt++;
    bus.req_valid = 6'b000000;
    tick();
    $display("txn rr_full idle: wr_en=%b a0=%0d", bus.wr_en, bus.wr_addr[0]);
    total_cnt++; if (bus.wr_en !== 3'b000) $display("FAIL idle_wr_en: got %b want 000", bus.wr_en); else pass_cnt++;
    total_cnt++; if (bus.wr_addr[0] !== 7'd13 || bus.wr_data[0] !== 32'h103)
      $display("FAIL idle_hold: got %0d/%h want 13/00000103", bus.wr_addr[0], bus.wr_data[0]); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd2) $display("FAIL idle_cnt: got %0d want 2", conflict_cnt); else pass_cnt++;
  endtask

  task automatic test_single();
    set_req(4, 7'd37, 32'hDEADBEEF);
    bus.req_valid = 6'b010000;
    #1;
    $display("txn single: ready=%b", bus.req_ready);
    total_cnt++; if (bus.req_ready !== 6'b010000) $display("FAIL single_ready: got %b want 010000", bus.req_ready); else pass_cnt++;
    tick();
    bus.req_valid = 6'b000000;
    $display("txn single out: wr_en=%b a0=%0d d0=%h", bus.wr_en, bus.wr_addr[0], bus.wr_data[0]);
    total_cnt++; if (bus.wr_en !== 3'b001) $display("FAIL single_wr_en: got %b want 001", bus.wr_en); else pass_cnt++;
    total_cnt++; if (bus.wr_addr[0] !== 7'd37) $display("FAIL single_addr: got %0d want 37", bus.wr_addr[0]); else pass_cnt++;
    total_cnt++; if (bus.wr_data[0] !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", bus.wr_data[0]); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd5) $display("FAIL single_ptr: got %0d want 5", dut.rr_ptr_reg); else pass_cnt++;
  endtask

  task automatic test_wrap();
    set_req(5, 7'd25, 32'hA5);
    set_req(0, 7'd20, 32'hA0);
    set_req(1, 7'd21, 32'hA1);
    bus.req_valid = 6'b100011;
    #1;
    $display("txn wrap: ready=%b", bus.req_ready);
    total_cnt++; if (bus.req_ready !== 6'b100011) $display("FAIL wrap_ready: got %b want 100011", bus.req_ready); else pass_cnt++;
    tick();
    bus.req_valid = 6'b000000;
    $display("txn wrap out: wr_en=%b a=%0d,%0d,%0d", bus.wr_en, bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]);
    total_cnt++; if (bus.wr_addr[0] !== 7'd25 || bus.wr_addr[1] !== 7'd20 || bus.wr_addr[2] !== 7'd21)
      $display("FAIL wrap_addr: got %0d,%0d,%0d want 25,20,21", bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]); else pass_cnt++;
    total_cnt++; if (bus.wr_data[0] !== 32'hA5) $display("FAIL wrap_data: got %h want 000000a5", bus.wr_data[0]); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd2) $display("FAIL wrap_ptr: got %0d want 2", dut.rr_ptr_reg); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd2) $display("FAIL wrap_cnt: got %0d want 2", conflict_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) set_req(i, 7'(10 + i), 32'h100 + i);
    bus.req_valid = 6'b111111;
    tick();
    $display("txn mid pre: wr_en=%b a0=%0d cnt=%0d", bus.wr_en, bus.wr_addr[0], conflict_cnt);
    total_cnt++; if (bus.wr_addr[0] !== 7'd12 || bus.wr_en !== 3'b111)
      $display("FAIL mid_pre: got %b/%0d want 111/12", bus.wr_en, bus.wr_addr[0]); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd3) $display("FAIL mid_pre_cnt: got %0d want 3", conflict_cnt); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.req_ready !== 6'b000000) $display("FAIL mid_ready: got %b want 000000", bus.req_ready); else pass_cnt++;
    tick();
    $display("txn mid reset: wr_en=%b ptr=%0d cnt=%0d", bus.wr_en, dut.rr_ptr_reg, conflict_cnt);
    total_cnt++; if (bus.wr_en !== 3'b000) $display("FAIL mid_wr_en: got %b want 000", bus.wr_en); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd0) $display("FAIL mid_ptr: got %0d want 0", dut.rr_ptr_reg); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd0) $display("FAIL mid_cnt: got %0d want 0", conflict_cnt); else pass_cnt++;
    rst_n = 1'b1;
    bus.req_valid = 6'b000000;
    tick();
    total_cnt++; if (bus.wr_en !== 3'b000) $display("FAIL mid_post: got %b want 000", bus.wr_en); else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    set_req(1, 7'd0, 32'h11);
    set_req(2, 7'd40, 32'h22);
    set_req(3, 7'd41, 32'h33);
    set_req(4, 7'd42, 32'h44);
    bus.req_valid = 6'b011110;
    #1;
    $display("txn zero: ready=%b", bus.req_ready);
`ifdef PRF_WB_ZERO_FILTER_EN
    total_cnt++; if (bus.req_ready !== 6'b011110) $display("FAIL zero_ready: got %b want 011110", bus.req_ready); else pass_cnt++;
    tick();
    bus.req_valid = 6'b000000;
    total_cnt++; if (bus.wr_addr[0] !== 7'd40 || bus.wr_addr[1] !== 7'd41 || bus.wr_addr[2] !== 7'd42)
      $display("FAIL zero_addr: got %0d,%0d,%0d want 40,41,42", bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd5) $display("FAIL zero_ptr: got %0d want 5", dut.rr_ptr_reg); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd0) $display("FAIL zero_cnt: got %0d want 0", conflict_cnt); else pass_cnt++;
    c0 = 0;
`else
    total_cnt++; if (bus.req_ready !== 6'b001110) $display("FAIL zero_ready: got %b want 001110", bus.req_ready); else pass_cnt++;
    tick();
    bus.req_valid = 6'b000000;
    total_cnt++; if (bus.wr_addr[0] !== 7'd0 || bus.wr_addr[1] !== 7'd40 || bus.wr_addr[2] !== 7'd41)
      $display("FAIL zero_addr: got %0d,%0d,%0d want 0,40,41", bus.wr_addr[0], bus.wr_addr[1], bus.wr_addr[2]); else pass_cnt++;
    total_cnt++; if (dut.rr_ptr_reg !== 3'd4) $display("FAIL zero_ptr: got %0d want 4", dut.rr_ptr_reg); else pass_cnt++;
    total_cnt++; if (conflict_cnt !== 16'd1) $display("FAIL zero_cnt: got %0d want 1", conflict_cnt); else pass_cnt++;
    c0 = 1;
`endif
    total_cnt++; if (bus.wr_en !== 3'b111) $display("FAIL zero_wr_en: got %b want 111", bus.wr_en); else pass_cnt++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) set_req(i, 7'(50 + i), 32'h200 + i);
    bus.req_valid = 6'b001111;
    repeat (65534 - c0) tick();
    $display("txn saturate near: cnt=%h", conflict_cnt);
    total_cnt++; if (conflict_cnt !== 16'hFFFE) $display("FAIL sat_near: got %h want fffe", conflict_cnt); else pass_cnt++;
    repeat (70000 - (65534 - c0)) tick();
    $display("txn saturate end: cnt=%h", conflict_cnt);
    total_cnt++; if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", conflict_cnt); else pass_cnt++;
    bus.req_valid = 6'b000000;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    c0        = 0;
    rst_n     = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_rr_full();
    test_single();
    test_wrap();
    test_reset_mid();
    test_zero_reg();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
